// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter and long-latency scoreboard.
// Shares the single RF write port between the ALU path (always wins) and a
// small FIFO of long-unit results. It tracks outstanding long writes and
// stalls issue on RAW/WAW hazards against them.
module rf_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            res,
  input  logic            iss_valid,
  input  logic            iss_long,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  output logic            stall,
  input  logic            alu_wr_en,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            wb_hold,
  output logic            rf_wr_en,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [31:0]     busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  // Control state (reset)
  logic [31:0]     busy_q,       busy_d;
  logic [CW-1:0]   count_q,      count_d;
  logic [PW-1:0]   wr_ptr_q,     wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,     rd_ptr_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            wb_hold_q,    wb_hold_d;

  // FIFO payload (not reset; validity is carried by count_q)
  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [4:0]      fifo_rd_d   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];
  logic [XLEN-1:0] fifo_data_d [DEPTH];

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            iss_accept;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign fifo_empty = (count_q == '0);
  assign head_rd    = fifo_rd_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign lu_ready   = (count_q < DEPTH_C);
  assign push       = lu_valid && lu_ready;
  assign stall      = iss_valid && (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd]);
  assign iss_accept = iss_valid && !stall;
  assign busy       = busy_q;
  assign wb_hold    = wb_hold_q;

  // Write-port mux: ALU has priority, otherwise drain the FIFO head.
  always_comb begin
    rf_wr_en = 1'b0;
    rd_addr  = 5'd0;
    wr_data  = '0;
    pop      = 1'b0;
    if (alu_wr_en) begin
      rf_wr_en = (alu_rd != 5'd0);
      rd_addr  = alu_rd;
      wr_data  = alu_data;
    end else if (!fifo_empty) begin
      pop      = 1'b1;
      rf_wr_en = (head_rd != 5'd0);
      rd_addr  = head_rd;
      wr_data  = head_data;
    end
  end

  // Scoreboard update: pop clears, accepted long issue sets (set wins).
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_rd] = 1'b0;
    end
    if (iss_accept && iss_long && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // FIFO pointers, occupancy and payload writes.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = lu_rd;
      fifo_data_d[wr_ptr_q] = lu_data;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation tracking: count deferred head cycles, then request an ALU hold.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    wb_hold_d    = wb_hold_q;
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
      wb_hold_d    = 1'b0;
    end else begin
      if (starve_cnt_q != STARVE_C) begin
        starve_cnt_d = starve_cnt_q + SW'(1);
      end
      if (starve_cnt_q == STARVE_C) begin
        wb_hold_d = 1'b1;
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      busy_q       <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      starve_cnt_q <= '0;
      wb_hold_q    <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      wb_hold_q    <= wb_hold_d;
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random ALU/long-unit
// traffic, with expected long-unit writes queued at acceptance.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        res;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        stall;
  logic        alu_wr_en;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        wb_hold, rf_wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] wr_data;
  logic [31:0] busy;

  int  total = 0;
  int  bad   = 0;
  wb_t exp_q[$];
  wb_t e_mon;
  logic acc;

  rf_wb_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .res(res),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .stall(stall),
    .alu_wr_en(alu_wr_en), .alu_rd(alu_rd), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .wb_hold(wb_hold), .rf_wr_en(rf_wr_en), .rd_addr(rd_addr), .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor: check every RF write; queue accepted long results in order.
  always @(negedge clk) begin
    if (!res) begin
      if (alu_wr_en) begin
        chk("alu_we", 64'(rf_wr_en), 64'(alu_rd != 5'd0));
        if (alu_rd != 5'd0) begin
          chk("alu_rd", 64'(rd_addr), 64'(alu_rd));
          chk("alu_data", 64'(wr_data), 64'(alu_data));
        end
      end else if (rf_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr", 64'(rf_wr_en), 64'd0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("lu_rd", 64'(rd_addr), 64'(e_mon.rd));
          chk("lu_data", 64'(wr_data), 64'(e_mon.data));
        end
      end
      if (lu_valid && lu_ready && (lu_rd != 5'd0)) begin
        exp_q.push_back('{rd: lu_rd, data: lu_data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1;
    iss_valid = 0; iss_long = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    alu_wr_en = 0; alu_rd = 0; alu_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    acc = 1'b0;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;

    // Reset then idle
    @(negedge clk);
    chk("rst_lu_ready", 64'(lu_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wb_hold", 64'(wb_hold), 64'd0);
    chk("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    // Long issue to x5, dependent issue stalls until pop + 1 cycle
    nxt();
    iss_valid = 1; iss_long = 1; iss_rd = 5; iss_rs1 = 1; iss_rs2 = 2;
    @(negedge clk);
    chk("raw_issue_nostall", 64'(stall), 64'd0);
    nxt();
    iss_long = 0; iss_rd = 6; iss_rs1 = 5; iss_rs2 = 0;
    lu_valid = 1; lu_rd = 5; lu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("raw_stall_wait", 64'(stall), 64'd1);
    chk("raw_busy5", 64'(busy), 64'h20);
    nxt();
    lu_valid = 0;
    @(negedge clk);
    chk("raw_stall_popcyc", 64'(stall), 64'd1);
    chk("raw_pop_we", 64'(rf_wr_en), 64'd1);
    chk("raw_pop_rd", 64'(rd_addr), 64'd5);
    chk("raw_pop_data", 64'(wr_data), 64'hDEADBEEF);
    nxt();
    @(negedge clk);
    chk("raw_release", 64'(stall), 64'd0);
    chk("raw_busy_clr", 64'(busy), 64'd0);
    nxt();
    iss_valid = 0; iss_rd = 0; iss_rs1 = 0;

    // Concurrent ALU x3 and long result x7
    alu_wr_en = 1; alu_rd = 3; alu_data = 32'h11;
    lu_valid = 1; lu_rd = 7; lu_data = 32'h22;
    @(negedge clk);
    chk("conc_alu_rd", 64'(rd_addr), 64'd3);
    chk("conc_alu_data", 64'(wr_data), 64'h11);
    nxt();
    alu_wr_en = 0; lu_valid = 0;
    @(negedge clk);
    chk("conc_lu_we", 64'(rf_wr_en), 64'd1);
    chk("conc_lu_rd", 64'(rd_addr), 64'd7);
    chk("conc_lu_data", 64'(wr_data), 64'h22);
    nxt();
    @(negedge clk);
    chk("conc_idle", 64'(rf_wr_en), 64'd0);
    chk("conc_drained", 64'(exp_q.size()), 64'd0);

    // Fill FIFO under continuous ALU traffic, starvation hold, then drain
    nxt();
    alu_wr_en = 1; alu_rd = 10; alu_data = 32'hA10;
    lu_valid = 1; lu_rd = 8; lu_data = 32'hA8;
    @(negedge clk);
    chk("fill_ready0", 64'(lu_ready), 64'd1);
    nxt();
    alu_rd = 11; alu_data = 32'hA11; lu_rd = 9; lu_data = 32'hA9;
    @(negedge clk);
    chk("fill_ready1", 64'(lu_ready), 64'd1);
    chk("fill_hold1", 64'(wb_hold), 64'd0);
    nxt();
    lu_valid = 0; alu_rd = 12; alu_data = 32'hA12;
    @(negedge clk);
    chk("fill_full", 64'(lu_ready), 64'd0);
    chk("fill_hold2", 64'(wb_hold), 64'd0);
    for (int i = 3; i < 6; i++) begin
      nxt();
      alu_rd = (i == 3) ? 5'd0 : 5'(10 + i);
      alu_data = 32'(i);
      @(negedge clk);
      chk("fill_hold_early", 64'(wb_hold), 64'd0);
      chk("fill_full_hold", 64'(lu_ready), 64'd0);
    end
    nxt();
    alu_rd = 16; alu_data = 32'hA16;
    @(negedge clk);
    chk("starve_hold", 64'(wb_hold), 64'd1);
    chk("starve_alu_wins", 64'(rd_addr), 64'd16);
    nxt();
    alu_wr_en = 0;
    @(negedge clk);
    chk("drain0_rd", 64'(rd_addr), 64'd8);
    chk("drain0_hold", 64'(wb_hold), 64'd1);
    chk("drain0_ready", 64'(lu_ready), 64'd0);
    nxt();
    @(negedge clk);
    chk("drain1_rd", 64'(rd_addr), 64'd9);
    chk("drain1_hold", 64'(wb_hold), 64'd0);
    chk("drain1_ready", 64'(lu_ready), 64'd1);
    nxt();
    @(negedge clk);
    chk("drain_idle", 64'(rf_wr_en), 64'd0);
    chk("drain_done", 64'(exp_q.size()), 64'd0);

    // x0 destination: no stall, no busy, pops silently
    nxt();
    iss_valid = 1; iss_long = 1; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    lu_valid = 1; lu_rd = 0; lu_data = 32'h55;
    @(negedge clk);
    chk("x0_stall", 64'(stall), 64'd0);
    nxt();
    iss_valid = 0; iss_long = 0;
    lu_rd = 12; lu_data = 32'h12C;
    @(negedge clk);
    chk("x0_busy", 64'(busy), 64'd0);
    chk("x0_pop_we", 64'(rf_wr_en), 64'd0);
    nxt();
    lu_valid = 0;
    @(negedge clk);
    chk("x0_next_we", 64'(rf_wr_en), 64'd1);
    chk("x0_next_rd", 64'(rd_addr), 64'd12);
    nxt();

    // Random mixed traffic against the scoreboard
    acc = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (acc || !lu_valid) begin
        lu_valid = 1'($urandom_range(0, 1));
        lu_rd    = 5'($urandom_range(0, 31));
        lu_data  = $urandom;
      end
      alu_wr_en = 1'($urandom_range(0, 1));
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      @(negedge clk);
      acc = lu_valid && lu_ready;
      nxt();
    end
    lu_valid = 0; alu_wr_en = 0;
    repeat (3) nxt();
    @(negedge clk);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_busy", 64'(busy), 64'd0);

    // Reset with two buffered entries and busy bits set
    nxt();
    alu_wr_en = 1; alu_rd = 1; alu_data = 32'h1;
    iss_valid = 1; iss_long = 1; iss_rd = 13;
    lu_valid = 1; lu_rd = 20; lu_data = 32'hB20;
    nxt();
    iss_rd = 14; lu_rd = 21; lu_data = 32'hB21;
    nxt();
    iss_valid = 0; iss_long = 0; iss_rd = 0; lu_valid = 0;
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'h6000);
    chk("pre_rst_full", 64'(lu_ready), 64'd0);
    nxt();
    res = 1'b1;
    exp_q.delete();
    nxt();
    res = 1'b0; alu_wr_en = 0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(lu_ready), 64'd1);
    chk("mid_rst_we", 64'(rf_wr_en), 64'd0);
    chk("mid_rst_hold", 64'(wb_hold), 64'd0);
    nxt();
    @(negedge clk);
    chk("mid_rst_we2", 64'(rf_wr_en), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback arbiter and scoreboard for the register file's single write port. It shares the port between the single-cycle ALU writeback path and a long-latency unit (load / mul-div) result stream, buffering long results in a small FIFO. It tracks registers with outstanding long-latency writes and raises a stall to the issue stage on RAW/WAW hazards. It sits between the execute/writeback stages and the register file write port (`rf_wr_en`, `rd_addr`, `wr_data`).

## Interface
- XLEN, 32, data width of register file and result buses
- DEPTH, 2, long-unit result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, cycles a FIFO head may be deferred by ALU writes before `wb_hold` is raised (≥1)

- clk  in  1  clock, all state updates on rising edge
- res  in  1  synchronous active-high reset
- iss_valid  in  1  instruction presented at issue this cycle
- iss_long  in  1  issuing instruction's result returns via long unit
- iss_rd  in  5  destination of issuing instruction
- iss_rs1  in  5  source 1 of issuing instruction
- iss_rs2  in  5  source 2 of issuing instruction
- stall  out  1  issue must not advance this cycle
- alu_wr_en  in  1  ALU result valid this cycle (no backpressure)
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  arbiter accepts long-unit result
- lu_rd  in  5  long-unit destination
- lu_data  in  XLEN  long-unit result
- wb_hold  out  1  core must keep `alu_wr_en` low this cycle
- rf_wr_en  out  1  register file write enable
- rd_addr  out  5  register file write address
- wr_data  out  XLEN  register file write data
- busy  out  32  scoreboard, bit n = write to xn outstanding

## Operation
- Scoreboard `busy[31:0]`, FIFO (count 0..DEPTH, rd/ptr wrap mod DEPTH), starvation counter `starve_cnt`, registered `wb_hold`.
- Issue acceptance: `iss_valid && !stall`. If also `iss_long && iss_rd != 0`, set `busy[iss_rd]`.
- `stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd])`. `busy[0]` is constant 0, so x0 never stalls.
- Long-unit handshake: `lu_ready = (count < DEPTH)`. The result is pushed on `lu_valid && lu_ready`. `lu_valid`/`lu_rd`/`lu_data` are held until accepted.
- Write port mux (combinational):
  - If `alu_wr_en`: drive ALU (rd, data). `rf_wr_en = (alu_rd != 0)`.
  - Else if FIFO non-empty: pop head. `rf_wr_en = (head.rd != 0)`.
  - Else `rf_wr_en = 0`, `rd_addr = 0`, `wr_data = 0`.
- Pop clears `busy[head.rd]`. If the same cycle accepts a long issue to the same rd, set wins. (Unreachable while busy stalls that rd; keep it defined.)
- ALU always wins, including when `wb_hold` is violated. The FIFO head is then deferred and the counter keeps counting.
- Starvation handling:
  - `starve_cnt` increments each cycle the FIFO is non-empty and no pop occurs. It clears on a pop or when the FIFO is empty.
  - `wb_hold` is registered and asserted the cycle after `starve_cnt` reaches STARVE_MAX. It deasserts the cycle after a pop.
- Push and pop in the same cycle are allowed when `count < DEPTH`. Count is then unchanged.
- A pushed entry is not popped in its push cycle. Minimum accept-to-RF-write latency is 1 cycle.

## Timing
- Reset values (registered state, next edge with `res`=1): `busy`=0, count=0, pointers=0, `starve_cnt`=0, `wb_hold`=0.
- Outputs after reset: `lu_ready`=1, `stall`=0. `rf_wr_en`/`rd_addr`/`wr_data` follow the ALU inputs, or are 0.
- Reset mid-operation: buffered results are discarded and the scoreboard is cleared. The long unit must also be reset by the same `res`.
- `busy` is registered. A reg cleared by a pop in cycle N still stalls in cycle N and releases in N+1 (no bypass).
- `stall`, `lu_ready` and the write-port signals are combinational from registered state plus the current cycle inputs.
- Full FIFO: `lu_ready`=0 until a pop. It rises in the cycle after the pop.
- Throughput: one RF write per cycle. Long results drain at one per cycle when the ALU is idle.

## Test plan
- Reset then idle: `lu_ready`=1, `busy`=0, `wb_hold`=0, `rf_wr_en`=0 with all inputs low.
- Long issue to x5, then an issue reading x5: `stall`=1 until the lu result for x5 (data 0xDEADBEEF) is popped. RF receives x5=0xDEADBEEF. `busy[5]` clears and `stall` drops one cycle after the pop.
- Concurrent ALU write x3=0x11 and lu result x7=0x22: cycle N writes x3. Cycle N+1 writes x7 if `alu_wr_en`=0.
- Fill FIFO (DEPTH=2) with `alu_wr_en` held high: `lu_ready`=0 after 2 accepts. `wb_hold` rises after STARVE_MAX=4 deferred cycles. Dropping `alu_wr_en` drains both entries in order, then `lu_ready`=1.
- Long issue to x0 and lu result with rd=0: no stall, `busy` stays 0, the entry pops with `rf_wr_en`=0.
- Assert `res` with 2 buffered entries and busy bits set: the next cycle shows `busy`=0, `lu_ready`=1, and no RF write of the discarded entries.
